// File: rtl/ram_be_requester.sv
// Request-side controller for the single-port 32-bit byte-enable RAM.
// It steers byte/half/word requests onto RAM lanes and returns in-order responses through a 4-entry FIFO.
module ram_be_requester #(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic [ADDRWIDTH+1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           ram_we,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [31:0]          ram_wr_data,
  input  logic [31:0]          ram_rd_data
);
  localparam int DEPTH = 4;

  typedef struct packed { logic err; logic [31:0] data; } rsp_t;
  typedef struct packed { logic write; logic [1:0] size; logic [1:0] lane; logic err; } meta_t;

  logic [2:0]       cnt;
  logic [1:0]       vld_pipe;  // [0] stage A, [1] stage B
  logic             accept, pop, req_err;
  logic [3:0]       we_c;
  logic [31:0]      wd_c, shifted;
  meta_t            a_meta, b_meta;
  rsp_t             push_rsp;
  rsp_t [DEPTH-1:0] q, sq, q_n;
  logic [DEPTH-1:0] qv, sv, qv_n;
  logic [DEPTH:0]   prev;

  assign req_ready = (cnt != 3'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    req_err = 1'b0;
    we_c    = 4'b0000;
    wd_c    = req_wdata;
    case (req_size)
      2'd0: begin we_c = 4'b0001 << req_addr[1:0]; wd_c = {4{req_wdata[7:0]}}; end
      2'd1: begin
        req_err = req_addr[0];
        we_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_c    = {2{req_wdata[15:0]}};
      end
      2'd2: begin req_err = (req_addr[1:0] != 2'b00); we_c = 4'b1111; end
      default: req_err = 1'b1;
    endcase
    if (!req_write || req_err) we_c = 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      vld_pipe    <= '0;
      a_meta      <= '0;
      b_meta      <= '0;
      ram_we      <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      ram_we   <= accept ? we_c : 4'b0000;
      if (accept) begin
        ram_addr    <= req_addr[ADDRWIDTH+1:2];
        ram_wr_data <= wd_c;
        a_meta      <= '{write: req_write, size: req_size, lane: req_addr[1:0], err: req_err};
      end
      b_meta <= a_meta;
    end
  end

  // Credits cover every in-flight request, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) cnt <= '0;
    else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    shifted      = ram_rd_data >> {b_meta.lane, 3'b000};
    push_rsp.err = b_meta.err;
    case (b_meta.size)
      2'd0:    push_rsp.data = {24'd0, shifted[7:0]};
      2'd1:    push_rsp.data = {16'd0, shifted[15:0]};
      default: push_rsp.data = shifted;
    endcase
    if (b_meta.write || b_meta.err) push_rsp.data = '0;
  end

  // Shift FIFO: entry 0 is the head and drives the outputs straight from flops.
  // Empty slots are kept at zero so rsp_rdata/rsp_err read 0 when idle.
  always_comb begin
    sv = pop ? (qv >> 1) : qv;
    for (int i = 0; i < DEPTH-1; i++) sq[i] = pop ? q[i+1] : q[i];
    sq[DEPTH-1] = pop ? '0 : q[DEPTH-1];
    prev = {sv, 1'b1};
    qv_n = sv;
    q_n  = sq;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_pipe[1] && !sv[i] && prev[i]) begin
        qv_n[i] = 1'b1;
        q_n[i]  = push_rsp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      qv <= '0;
      q  <= '0;
    end else begin
      qv <= qv_n;
      q  <= q_n;
    end
  end

  assign rsp_valid = qv[0];
  assign rsp_rdata = q[0].data;
  assign rsp_err   = q[0].err;
endmodule

// File: tb/tb_ram_be_requester.sv
// Bench for ram_be_requester: behavioural RAM, byte-array reference memory and an in-order response scoreboard.
module tb_ram_be_requester;
  logic        clk, reset_l;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wr_data, ram_rd_data;

  ram_be_requester #(.ADDRWIDTH(8)) dut (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read.
  logic [31:0] ram_mem [0:255];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wr_data[8*i +: 8];
    ram_rd_data <= ram_mem[ram_addr];
  end

  typedef struct { logic err; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  exp_t        ex;
  logic [7:0]  ref_mem [0:1023];
  int          tests, fails, pop_cnt, mn;
  logic [3:0]  we_pend;
  logic        chk_pend, bad;
  logic [7:0]  addr_pend;
  logic [31:0] wd_pend;
  logic [1:0]  lane_pend;

  function automatic logic ref_err(input logic [1:0] sz, input logic [9:0] a);
    if (sz == 2'd3) return 1'b1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  // Scoreboard: actions observed at the negedge take effect at the following posedge.
  always @(negedge clk) begin
    if (!reset_l) begin
      exp_q.delete();
      we_pend  = 4'b0;
      chk_pend = 1'b0;
    end else begin
      tests++;
      if (ram_we !== we_pend) begin
        fails++; $display("FAIL ram_we: got %b expected %b", ram_we, we_pend);
      end
      if (chk_pend) begin
        bad = (ram_addr !== addr_pend);
        for (int j = 0; j < 4; j++)
          if (we_pend[j] && ram_wr_data[8*j +: 8] !== wd_pend[8*(j-int'(lane_pend)) +: 8]) bad = 1'b1;
        tests++;
        if (bad) begin
          fails++; $display("FAIL ram_port: addr %h wr_data %h, expected addr %h lanes %b of data %h lane %0d",
                            ram_addr, ram_wr_data, addr_pend, we_pend, wd_pend, lane_pend);
        end
      end
      if (rsp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rsp_unexpected: err %b data %h with nothing outstanding", rsp_err, rsp_rdata);
        end else begin
          if (rsp_err !== exp_q[0].err || rsp_rdata !== exp_q[0].data) begin
            fails++; $display("FAIL rsp_data: got err %b data %h expected err %b data %h",
                              rsp_err, rsp_rdata, exp_q[0].err, exp_q[0].data);
          end
          if (rsp_ready) begin void'(exp_q.pop_front()); pop_cnt++; end
        end
      end
      we_pend  = 4'b0;
      chk_pend = 1'b0;
      if (req_valid && req_ready) begin
        mn = 1 << req_size;
        ex.err  = ref_err(req_size, req_addr);
        ex.data = 32'h0;
        if (!ex.err)
          for (int i = 0; i < mn; i++) begin
            if (req_write) begin
              ref_mem[int'(req_addr) + i] = req_wdata[8*i +: 8];
              we_pend[int'(req_addr[1:0]) + i] = 1'b1;
            end else ex.data[8*i +: 8] = ref_mem[int'(req_addr) + i];
          end
        exp_q.push_back(ex);
        chk_pend  = 1'b1;
        addr_pend = req_addr[9:2];
        wd_pend   = req_wdata;
        lane_pend = req_addr[1:0];
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic [9:0] a, input logic [31:0] d);
    int g;
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 100) begin @(negedge clk); g++; end
    if (!req_ready) begin tests++; fails++; $display("FAIL send_timeout: req_ready %b expected 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) begin tests++; fails++; $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Single isolated transaction; returns ram_we in N+1, rsp_valid in N+2 and the response in N+3.
  task automatic one_txn(input logic w, input logic [1:0] sz, input logic [9:0] a, input logic [31:0] d,
                         output logic [3:0] we_o, output logic early_o, output logic [33:0] rsp_o);
    drain();
    send(w, sz, a, d);
    req_valid = 1'b0;
    we_o = ram_we;
    @(posedge clk); #1;
    early_o = rsp_valid;
    @(posedge clk); #1;
    rsp_o = {rsp_valid, rsp_err, rsp_rdata};
  endtask

  task automatic rand_req(input logic w, input int max_sz);
    req_write = w;
    req_size  = 2'($urandom_range(0, max_sz));
    req_addr  = 10'h100 + 10'($urandom_range(0, 63));
    req_wdata = $urandom;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({ram_we, ram_addr, ram_wr_data, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      fails++; $display("FAIL reset_outputs: we %b addr %h wd %h rv %b err %b rd %h expected all 0",
                        ram_we, ram_addr, ram_wr_data, rsp_valid, rsp_err, rsp_rdata);
    end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    @(negedge clk) reset_l = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset: ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_word_rw();
    drain();
    send(1'b1, 2'd2, 10'h010, 32'hDEADBEEF);
    send(1'b0, 2'd2, 10'h010, 32'h0);
    req_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_latency: rsp_valid %b expected 0", rsp_valid); end
    @(posedge clk); #1;
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL wr_rsp: valid %b err %b data %h expected 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      fails++; $display("FAIL rd_rsp: valid %b err %b data %h expected 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_byte_lanes();
    logic [3:0]  we_o;
    logic        early;
    logic [33:0] r;
    logic [1:0]  rsz [3] = '{2'd2, 2'd1, 2'd0};
    logic [9:0]  radr [3] = '{10'h020, 10'h022, 10'h023};
    logic [31:0] rexp [3] = '{32'h44332211, 32'h00004433, 32'h00000044};
    for (int i = 0; i < 4; i++) begin
      one_txn(1'b1, 2'd0, 10'(10'h020 + i), 32'(8'h11 * (i + 1)), we_o, early, r);
      tests++;
      if (we_o !== 4'(1 << i)) begin fails++; $display("FAIL byte_we%0d: got %b expected %b", i, we_o, 4'(1 << i)); end
      tests++;
      if (early !== 1'b0 || r !== {2'b10, 32'h0}) begin
        fails++; $display("FAIL byte_wr_rsp%0d: early %b rsp %h expected 0 %h", i, early, r, {2'b10, 32'h0});
      end
    end
    for (int i = 0; i < 3; i++) begin
      one_txn(1'b0, rsz[i], radr[i], 32'h0, we_o, early, r);
      tests++;
      if (we_o !== 4'b0 || r !== {2'b10, rexp[i]}) begin
        fails++; $display("FAIL lane_read%0d: we %b rsp %h expected 0000 %h", i, we_o, r, {2'b10, rexp[i]});
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  we_o;
    logic        early;
    logic [33:0] r;
    logic        ew [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  esz [3] = '{2'd1, 2'd2, 2'd3};
    logic [9:0]  eadr [3] = '{10'h031, 10'h022, 10'h040};
    for (int i = 0; i < 3; i++) begin
      one_txn(ew[i], esz[i], eadr[i], 32'hA5A5A5A5, we_o, early, r);
      tests++;
      if (we_o !== 4'b0 || early !== 1'b0 || r !== {2'b11, 32'h0}) begin
        fails++; $display("FAIL err_req%0d: we %b early %b rsp %h expected 0000 0 %h", i, we_o, early, r, {2'b11, 32'h0});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0]  adr [6];
    logic [31:0] h;
    int acc, gap, base;
    drain();
    for (int i = 0; i < 6; i++) adr[i] = 10'($urandom_range(0, 15) * 4);
    base = pop_cnt; acc = 0; gap = 0;
    rsp_ready = 1'b0; req_write = 1'b0; req_size = 2'd2; req_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1; req_addr = adr[acc];
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    tests++;
    if (acc !== 4 || req_ready !== 1'b0) begin
      fails++; $display("FAIL bp_accept: accepted %0d ready %b expected 4 0", acc, req_ready);
    end
    h = rsp_rdata;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== h) begin
      fails++; $display("FAIL bp_head_stable: valid %b data %h expected 1 %h", rsp_valid, rsp_rdata, h);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc < 6) begin req_valid = 1'b1; req_addr = adr[acc]; end
      else req_valid = 1'b0;
      @(negedge clk);
      if (c < 4 && rsp_valid !== 1'b1) gap++;
      if (req_valid && req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    tests++;
    if (acc !== 6 || gap !== 0) begin fails++; $display("FAIL bp_release: accepted %0d gaps %0d expected 6 0", acc, gap); end
    drain();
    tests++;
    if (pop_cnt - base !== 6) begin fails++; $display("FAIL bp_count: responses %0d expected 6", pop_cnt - base); end
  endtask

  task automatic test_streaming();
    int drops, gaps, base;
    drain();
    drops = 0; gaps = 0; base = pop_cnt;
    for (int c = 0; c < 32; c++) begin
      rand_req(c < 16, 2);
      req_valid = 1'b1;
      @(negedge clk);
      if (!req_ready) drops++;
      if (c >= 3 && !rsp_valid) gaps++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    tests++;
    if (drops !== 0 || gaps !== 0) begin fails++; $display("FAIL stream: ready drops %0d gaps %0d expected 0 0", drops, gaps); end
    drain();
    tests++;
    if (pop_cnt - base !== 32) begin fails++; $display("FAIL stream_count: responses %0d expected 32", pop_cnt - base); end
  endtask

  task automatic test_random();
    int acc;
    logic took;
    drain();
    acc = 0;
    rand_req(1'($urandom_range(0, 1)), 3);
    for (int c = 0; c < 3000 && acc < 150; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = req_valid && req_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) rand_req(1'($urandom_range(0, 1)), 3);
    end
    req_valid = 1'b0;
    tests++;
    if (acc !== 150) begin fails++; $display("FAIL random_accepts: %0d expected 150", acc); end
    drain();
  endtask

  task automatic test_reset_midflight();
    int stale;
    drain();
    send(1'b0, 2'd2, 10'h010, 32'h0);
    send(1'b0, 2'd2, 10'h020, 32'h0);
    send(1'b0, 2'd0, 10'h023, 32'h0);
    req_valid = 1'b0;
    #1 reset_l = 1'b0;
    #1;
    tests++;
    if ({ram_we, ram_addr, ram_wr_data, rsp_valid, rsp_err, rsp_rdata} !== '0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_outputs: we %b addr %h wd %h rv %b err %b rd %h ready %b expected zeros ready 1",
                        ram_we, ram_addr, ram_wr_data, rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_l = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    tests++;
    if (stale !== 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_stale: stale %0d ready %b expected 0 1", stale, req_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; pop_cnt = 0;
    we_pend = 4'b0; chk_pend = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    ram_rd_data = 32'h0;
    reset_l = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 10'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
